regfile_sb: RTL and testbench

Parametrised general-purpose register file for the pipelined CPU datapath: two combinational read ports, one write port, optional write-to-read bypass, hardwired zero register and an integrated per-register scoreboard. Decode reads operands and reserves the destination register of each issued instruction. Writeback writes the result and releases the reservation. A per-port hazard flag tells decode to stall while an operand is still pending.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_sb_if.sv | 29 ++
 rtl/reg_scoreboard.sv | 63 ++++++
 rtl/regfile_sb.sv | 68 ++++++
 tb/tb_regfile_sb.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_sb register file and its scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_IDX   = 0;
  // The popcount helper takes a fixed-width vector, so ADDR_W is limited to 8.
  localparam int MAX_DEPTH  = 256;

  function automatic int unsigned pend_popcount(input logic [MAX_DEPTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback port bundle of the register file. master = datapath, slave = register file.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              hazard1;
  logic              hazard2;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W:0]   pend_cnt;

  // No handshake: reads are combinational, writes/reserves take effect on the clock edge,
  // and the datapath must not issue while hazard1 or hazard2 is high.
  modport master (
    output rd_addr1, rd_addr2, we, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data1, rd_data2, hazard1, hazard2, pend_cnt
  );
  modport slave (
    input  rd_addr1, rd_addr2, we, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data1, rd_data2, hazard1, hazard2, pend_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: reserve sets, writeback clears (reserve wins), plus hazard flags and count.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rsv_en,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic              o_hazard1,
  output logic              o_hazard2,
  output logic [ADDR_W:0]   o_pend_cnt
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

  logic [DEPTH-1:0]     r_pend;
  logic [ADDR_W:0]      r_pend_cnt;
  logic [DEPTH-1:0]     w_pend_next;
  logic [MAX_DEPTH-1:0] w_pend_ext;
  logic [ADDR_W:0]      w_cnt_next;
  logic                 w_byp1;
  logic                 w_byp2;

  // Clear first, then set, so a same-cycle reserve keeps the register owned by the new instruction.
  always_comb begin
    w_pend_next = r_pend;
    if (i_we && !(ZERO_REG != 0 && i_wr_addr == ZERO_A)) begin
      w_pend_next[i_wr_addr] = 1'b0;
    end
    if (i_rsv_en && !(ZERO_REG != 0 && i_rsv_addr == ZERO_A)) begin
      w_pend_next[i_rsv_addr] = 1'b1;
    end
  end

  assign w_pend_ext = MAX_DEPTH'(w_pend_next);
  assign w_cnt_next = (ADDR_W + 1)'(pend_popcount(w_pend_ext));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend     <= w_pend_next;
      r_pend_cnt <= w_cnt_next;
    end
  end

  assign w_byp1 = (BYPASS != 0) && i_we && (i_wr_addr == i_rd_addr1);
  assign w_byp2 = (BYPASS != 0) && i_we && (i_wr_addr == i_rd_addr2);

  assign o_hazard1  = r_pend[i_rd_addr1] && !w_byp1 && !(ZERO_REG != 0 && i_rd_addr1 == ZERO_A);
  assign o_hazard2  = r_pend[i_rd_addr2] && !w_byp2 && !(ZERO_REG != 0 && i_rd_addr2 == ZERO_A);
  assign o_pend_cnt = r_pend_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Register file: storage array, two combinational read ports with optional write bypass, zero register.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic rst,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_wr_ok;

  assign w_wr_ok = bus.we && !(ZERO_REG != 0 && bus.wr_addr == ZERO_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Priority: zero register, then same-cycle write forwarding, then the array.
  always_comb begin
    w_rd1 = r_mem[bus.rd_addr1];
    if (BYPASS != 0 && bus.we && bus.wr_addr == bus.rd_addr1) w_rd1 = bus.wr_data;
    if (ZERO_REG != 0 && bus.rd_addr1 == ZERO_A) w_rd1 = '0;
  end

  always_comb begin
    w_rd2 = r_mem[bus.rd_addr2];
    if (BYPASS != 0 && bus.we && bus.wr_addr == bus.rd_addr2) w_rd2 = bus.wr_data;
    if (ZERO_REG != 0 && bus.rd_addr2 == ZERO_A) w_rd2 = '0;
  end

  assign bus.rd_data1 = w_rd1;
  assign bus.rd_data2 = w_rd2;

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_rsv_en   (bus.rsv_en),
    .i_rsv_addr (bus.rsv_addr),
    .i_we       (bus.we),
    .i_wr_addr  (bus.wr_addr),
    .i_rd_addr1 (bus.rd_addr1),
    .i_rd_addr2 (bus.rd_addr2),
    .o_hazard1  (bus.hazard1),
    .o_hazard2  (bus.hazard2),
    .o_pend_cnt (bus.pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one BYPASS=1 and one BYPASS=0 instance driven with the same vectors.
module tb_regfile_sb;

  typedef struct packed {
    logic        dut;   // 0: BYPASS=1 instance, 1: BYPASS=0 instance
    logic [4:0]  mask;  // d1, d2, h1, h2, cnt
    logic [31:0] d1;
    logic [31:0] d2;
    logic        h1;
    logic        h2;
    logic [5:0]  cnt;
    logic [7:0]  tag;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic clk;
  logic rst;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
  logic        we, rsv_en;
  logic [31:0] wr_data;

  logic [EXP_W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

  assign bus_a.rd_addr1 = rd_addr1;  assign bus_b.rd_addr1 = rd_addr1;
  assign bus_a.rd_addr2 = rd_addr2;  assign bus_b.rd_addr2 = rd_addr2;
  assign bus_a.we       = we;        assign bus_b.we       = we;
  assign bus_a.wr_addr  = wr_addr;   assign bus_b.wr_addr  = wr_addr;
  assign bus_a.wr_data  = wr_data;   assign bus_b.wr_data  = wr_data;
  assign bus_a.rsv_en   = rsv_en;    assign bus_b.rsv_en   = rsv_en;
  assign bus_a.rsv_addr = rsv_addr;  assign bus_b.rsv_addr = rsv_addr;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic w,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic r, input logic [4:0] ra);
    rd_addr1 = a1; rd_addr2 = a2; we = w; wr_addr = wa; wr_data = wd;
    rsv_en = r; rsv_addr = ra;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    set_in(a1, a2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic exp_push(input logic d, input logic [4:0] m, input logic [31:0] d1,
                          input logic [31:0] d2, input logic h1, input logic h2,
                          input logic [5:0] cnt, input logic [7:0] tag);
    exp_t e;
    e.dut = d; e.mask = m; e.d1 = d1; e.d2 = d2; e.h1 = h1; e.h2 = h2; e.cnt = cnt; e.tag = tag;
    exp_q.push_back(EXP_W'(e));
  endtask

  task automatic exp_both(input logic [4:0] m, input logic [31:0] d1, input logic [31:0] d2,
                          input logic h1, input logic h2, input logic [5:0] cnt,
                          input logic [7:0] tag);
    exp_push(1'b0, m, d1, d2, h1, h2, cnt, tag);
    exp_push(1'b1, m, d1, d2, h1, h2, cnt, tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard: outputs are combinational, sampled mid-cycle on the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] g_d1, g_d2;
      logic g_h1, g_h2;
      logic [5:0] g_cnt;
      e = exp_t'(exp_q.pop_front());
      if (e.dut == 1'b0) begin
        g_d1 = bus_a.rd_data1; g_d2 = bus_a.rd_data2;
        g_h1 = bus_a.hazard1;  g_h2 = bus_a.hazard2;  g_cnt = bus_a.pend_cnt;
      end else begin
        g_d1 = bus_b.rd_data1; g_d2 = bus_b.rd_data2;
        g_h1 = bus_b.hazard1;  g_h2 = bus_b.hazard2;  g_cnt = bus_b.pend_cnt;
      end
      if (e.mask[4]) begin
        n_vec++;
        if (g_d1 !== e.d1) begin
          n_err++;
          $display("FAIL rd_data1 tag=%0d dut=%0d got=%h want=%h", e.tag, e.dut, g_d1, e.d1);
        end
      end
      if (e.mask[3]) begin
        n_vec++;
        if (g_d2 !== e.d2) begin
          n_err++;
          $display("FAIL rd_data2 tag=%0d dut=%0d got=%h want=%h", e.tag, e.dut, g_d2, e.d2);
        end
      end
      if (e.mask[2]) begin
        n_vec++;
        if (g_h1 !== e.h1) begin
          n_err++;
          $display("FAIL hazard1 tag=%0d dut=%0d got=%b want=%b", e.tag, e.dut, g_h1, e.h1);
        end
      end
      if (e.mask[1]) begin
        n_vec++;
        if (g_h2 !== e.h2) begin
          n_err++;
          $display("FAIL hazard2 tag=%0d dut=%0d got=%b want=%b", e.tag, e.dut, g_h2, e.h2);
        end
      end
      if (e.mask[0]) begin
        n_vec++;
        if (g_cnt !== e.cnt) begin
          n_err++;
          $display("FAIL pend_cnt tag=%0d dut=%0d got=%0d want=%0d", e.tag, e.dut, g_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    idle(5'd0, 5'd0);
    step();
    step();
    rst = 1'b0;

    // after reset: every address reads 0 with no hazard on both ports
    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(31 - i));
      exp_both(5'b11111, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 8'd1);
      step();
    end

    // reserve r3: no hazard in the reserve cycle, hazard the next
    set_in(5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    exp_both(5'b10111, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 8'd2);
    step();
    idle(5'd3, 5'd0);
    exp_both(5'b10111, 32'd0, 32'd0, 1'b1, 1'b0, 6'd1, 8'd3);
    step();
    // writeback r3: forwarded only with bypass
    set_in(5'd3, 5'd0, 1'b1, 5'd3, 32'h0000_1234, 1'b0, 5'd0);
    exp_push(1'b0, 5'b10101, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 6'd1, 8'd4);
    exp_push(1'b1, 5'b10101, 32'h0000_0000, 32'd0, 1'b1, 1'b0, 6'd1, 8'd4);
    step();
    idle(5'd3, 5'd0);
    exp_both(5'b10101, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 6'd0, 8'd5);
    step();

    // reserve and write r7 in the same cycle: reserve wins, data still lands
    set_in(5'd7, 5'd3, 1'b1, 5'd7, 32'h0000_7777, 1'b1, 5'd7);
    exp_push(1'b0, 5'b11111, 32'h0000_7777, 32'h0000_1234, 1'b0, 1'b0, 6'd0, 8'd6);
    exp_push(1'b1, 5'b11111, 32'h0000_0000, 32'h0000_1234, 1'b0, 1'b0, 6'd0, 8'd6);
    step();
    idle(5'd7, 5'd3);
    exp_both(5'b11111, 32'h0000_7777, 32'h0000_1234, 1'b1, 1'b0, 6'd1, 8'd7);
    step();
    set_in(5'd7, 5'd0, 1'b1, 5'd7, 32'h0000_8888, 1'b0, 5'd0);
    exp_push(1'b0, 5'b10101, 32'h0000_8888, 32'd0, 1'b0, 1'b0, 6'd1, 8'd8);
    exp_push(1'b1, 5'b10101, 32'h0000_7777, 32'd0, 1'b1, 1'b0, 6'd1, 8'd8);
    step();
    idle(5'd7, 5'd0);
    exp_both(5'b10101, 32'h0000_8888, 32'd0, 1'b0, 1'b0, 6'd0, 8'd9);
    step();

    // zero register ignores write and reserve; r5 pending keeps the count at 1
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    step();
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0);
    exp_both(5'b11111, 32'd0, 32'd0, 1'b0, 1'b0, 6'd1, 8'd10);
    step();
    idle(5'd0, 5'd5);
    exp_both(5'b11111, 32'd0, 32'd0, 1'b0, 1'b1, 6'd1, 8'd11);
    step();
    set_in(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
    step();
    idle(5'd5, 5'd0);
    exp_both(5'b10101, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 6'd0, 8'd12);
    step();

    // mid-run reset overrides a same-cycle write and reserve
    rst = 1'b1;
    set_in(5'd5, 5'd9, 1'b1, 5'd5, 32'h0000_0001, 1'b1, 5'd9);
    step();
    rst = 1'b0;
    idle(5'd5, 5'd9);
    exp_both(5'b11111, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 8'd13);
    step();

    // reserve r1..r31 back to back
    for (int i = 1; i < 32; i++) begin
      set_in(5'(i), 5'(i - 1), 1'b0, 5'd0, 32'd0, 1'b1, 5'(i));
      exp_both(5'b00111, 32'd0, 32'd0, 1'b0, (i > 1), 6'(i - 1), 8'd14);
      step();
    end
    idle(5'd31, 5'd1);
    exp_both(5'b00111, 32'd0, 32'd0, 1'b1, 1'b1, 6'd31, 8'd15);
    step();

    // release in reverse order: count drops by one per cycle
    for (int i = 31; i >= 1; i--) begin
      logic [31:0] wd;
      wd = 32'(i) * 32'h0101_0101;
      set_in(5'(i), 5'(i - 1), 1'b1, 5'(i), wd, 1'b0, 5'd0);
      exp_push(1'b0, 5'b10111, wd, 32'd0, 1'b0, (i > 1), 6'(i), 8'd16);
      exp_push(1'b1, 5'b10111, 32'd0, 32'd0, 1'b1, (i > 1), 6'(i), 8'd16);
      step();
    end
    idle(5'd31, 5'd1);
    exp_both(5'b11111, 32'h1F1F_1F1F, 32'h0101_0101, 1'b0, 1'b0, 6'd0, 8'd17);
    step();

    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d want=0 entries left", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
